// File: rtl/accel_fifo.sv
// Single-clock FIFO between the bus router and one accelerator.
// Registered read port, count-based occupancy, sticky protocol-error flags.
module accel_fifo #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  put_req,
  input  logic [WIDTH-1:0]      data_in,
  input  logic                  get_req,
  output logic [WIDTH-1:0]      data_out,
  output logic                  data_valid,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] ONE   = (ADDR_WIDTH+1)'(1);

  logic [WIDTH-1:0]      mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic                  wr_acc, rd_acc;

  // Status decodes only from registered count, so no request-to-output path.
  assign empty = (count == '0);
  assign full  = (count == DEPTH);

  always_comb begin
    wr_acc = put_req && (!full || get_req);
    rd_acc = get_req && !empty;
  end

  // Storage is not reset; a write on the reset edge is still dropped.
  always_ff @(posedge clk) begin
    if (reset && wr_acc) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      data_valid <= rd_acc;
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) begin
        // On full with simultaneous put, rd_ptr == wr_ptr: this sees the old word.
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
      if (put_req && full && !get_req) overflow  <= 1'b1;
      if (get_req && empty)            underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_accel_fifo.sv
// Directed bench for accel_fifo: expected read words are queued when a get is
// issued and a negedge monitor pops and compares them on each data_valid.
module tb_accel_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        put_req, get_req;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        data_valid, empty, full, overflow, underflow;
  logic [4:0]  count;

  int n_total = 0;
  int n_pass  = 0;
  logic [31:0] exp_q [$];

  accel_fifo #(.WIDTH(32), .ADDR_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .put_req(put_req), .data_in(data_in),
    .get_req(get_req), .data_out(data_out), .data_valid(data_valid),
    .empty(empty), .full(full), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Monitor: every data_valid pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset === 1'b1 && data_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_valid: got data_out 0x%08h expected no data_valid", data_out);
      end else begin
        chk("read_data", data_out, exp_q.pop_front());
      end
    end
  end

  // Drive at negedge, let one posedge take it, return at the next negedge.
  task automatic cyc(input logic p, input logic [31:0] d, input logic g);
    put_req = p; data_in = d; get_req = g;
    @(posedge clk);
    @(negedge clk);
    put_req = 1'b0; get_req = 1'b0; data_in = '0;
  endtask

  task automatic get_exp(input logic [31:0] w);
    exp_q.push_back(w);
    cyc(1'b0, 32'h0, 1'b1);
  endtask

  initial begin
    reset = 1'b0; put_req = 1'b0; get_req = 1'b0; data_in = '0;
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(data_valid), 32'd0);
    chk("rst_data_out", data_out, 32'h0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_underflow", 32'(underflow), 32'd0);

    // Fill 0x1..0x10
    for (int i = 1; i <= 16; i++) cyc(1'b1, 32'(i), 1'b0);
    chk("fill_count", 32'(count), 32'd16);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_empty", 32'(empty), 32'd0);

    // Overflow: dropped write, sticky flag
    cyc(1'b1, 32'hDEADBEEF, 1'b0);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd16);

    for (int i = 1; i <= 16; i++) get_exp(32'(i));
    cyc(1'b0, 32'h0, 1'b0);
    chk("pulse_one_cycle", 32'(data_valid), 32'd0);
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_count", 32'(count), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    chk("drain_data_hold", data_out, 32'h10);

    // Put+get on empty: write wins, read rejected
    cyc(1'b1, 32'hA5A5A5A5, 1'b1);
    chk("unf_flag", 32'(underflow), 32'd1);
    chk("unf_valid", 32'(data_valid), 32'd0);
    chk("unf_count", 32'(count), 32'd1);
    get_exp(32'hA5A5A5A5);
    chk("unf_drain_count", 32'(count), 32'd0);

    // Put+get on full, pointers no longer at 0 so this wraps
    for (int i = 1; i <= 16; i++) cyc(1'b1, 32'(i), 1'b0);
    chk("refill_full", 32'(full), 32'd1);
    exp_q.push_back(32'h1);
    cyc(1'b1, 32'h11, 1'b1);
    chk("full_pg_count", 32'(count), 32'd16);
    chk("full_pg_full", 32'(full), 32'd1);
    for (int i = 2; i <= 17; i++) get_exp(32'(i));
    chk("wrap_empty", 32'(empty), 32'd1);

    // Reset mid-stream with a get on the reset edge
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h100 + 32'(i), 1'b0);
    chk("mid_count_pre", 32'(count), 32'd5);
    reset = 1'b0; get_req = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b1; get_req = 1'b0;
    chk("mid_valid", 32'(data_valid), 32'd0);
    chk("mid_count", 32'(count), 32'd0);
    chk("mid_empty", 32'(empty), 32'd1);
    chk("mid_data_out", data_out, 32'h0);
    chk("mid_overflow", 32'(overflow), 32'd0);
    chk("mid_underflow", 32'(underflow), 32'd0);
    cyc(1'b0, 32'h0, 1'b0);
    chk("mid_valid_next", 32'(data_valid), 32'd0);
    cyc(1'b1, 32'h7, 1'b0);
    get_exp(32'h7);
    chk("post_count", 32'(count), 32'd0);

    cyc(1'b0, 32'h0, 1'b0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/accel_fifo.md
Name: accel_fifo

Overview:
- Synchronous single-clock FIFO between the data bus router and one accelerator (FFT, FIR or IIR); one instance per direction per accelerator.
- Router side writes with put_req and reads with get_req. Accelerator side does the same.
- Exports empty/full status; these drive the router's to_*/from_* empty/full inputs.
- 32-bit data path, registered read output, sticky error flags for protocol violations.

Parameters:
- WIDTH, 32, data word width in bits
- ADDR_WIDTH, 4, pointer width; depth = 2**ADDR_WIDTH (16 entries)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- put_req  input  1  write strobe; data_in is written on this edge when accepted
- data_in  input  WIDTH  write data
- get_req  input  1  read strobe; pops the head entry when accepted
- data_out  output  WIDTH  registered read data
- data_valid  output  1  one-cycle pulse: data_out holds the word popped on the previous edge
- empty  output  1  count == 0
- full  output  1  count == 2**ADDR_WIDTH
- count  output  ADDR_WIDTH+1  current occupancy
- overflow  output  1  sticky: put_req seen while full and not simultaneously popped
- underflow  output  1  sticky: get_req seen while empty

Behaviour:
- Reset is sampled only on the rising clk edge while reset==0. It clears:
  - wr_ptr, rd_ptr and count to 0
  - data_out to 0, data_valid to 0
  - overflow and underflow to 0
  - empty to 1, full to 0
- Reset has priority over all requests; a request on the reset edge is ignored.
- Storage: 2**ADDR_WIDTH x WIDTH register array. Contents are not cleared by reset and are don't-care until written.
- Pointers are ADDR_WIDTH bits wide and wrap naturally from 2**ADDR_WIDTH-1 to 0. Occupancy is tracked only by count.
- Write accepted = put_req && (!full || get_req).
  - On accept: mem[wr_ptr] <= data_in; wr_ptr <= wr_ptr+1.
- Read accepted = get_req && !empty.
  - On accept: data_out <= mem[rd_ptr]; rd_ptr <= rd_ptr+1; data_valid <= 1.
  - Otherwise data_valid <= 0 and data_out holds its last value.
- Read latency: one cycle. get_req at edge N gives data_out/data_valid valid after edge N, for one cycle only.
- count update per edge:
  - +1 on write-only accept
  - -1 on read-only accept
  - unchanged when both are accepted, or when neither is
- empty and full are combinational decodes of count. They are glitch-free because count is registered.
- Simultaneous put and get:
  - Empty: the write is accepted; the read is rejected and underflow is set. The new word does not bypass to data_out.
  - Full: both are accepted; count stays at max; the head is read before overwrite because rd_ptr == wr_ptr is read and written in the same edge. The read uses the old array value.
  - Otherwise: both are accepted; count is unchanged.
- Overflow: put_req && full && !get_req sets overflow. The write is dropped and no state other than overflow changes.
- Underflow: get_req && empty sets underflow. No pointer moves and data_valid stays 0.
- overflow and underflow are sticky and clear only on reset.
- Reset mid-stream: all in-flight state is discarded. A data_valid pulse due on the next edge is suppressed (it stays 0).
- No combinational path from put_req or get_req to any output.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, then reset=1 -> empty=1, full=0, count=0, data_valid=0, data_out=0, overflow=0, underflow=0.
- Fill and drain: put 16 words 0x00000001..0x00000010 back-to-back.
  - count reaches 16 and full=1 after the 16th edge.
  - Then 16 get_req -> data_out sequence 0x1..0x10, each with a data_valid pulse one cycle after its get_req.
  - Ends with empty=1, count=0.
- Overflow: with the FIFO full, put 0xDEADBEEF with no get -> overflow=1, count stays 16, and the drain sequence is unchanged (0x1..0x10). overflow stays 1 until reset.
- Underflow and simultaneous put/get on empty: put_req=1 with 0xA5A5A5A5 and get_req=1 on an empty FIFO -> underflow=1, data_valid=0, count=1. The next get_req returns 0xA5A5A5A5.
- Simultaneous put/get when full: from full (0x1..0x10), put 0x11 with get -> data_out=0x1, count=16. The following 16 reads return 0x2..0x11, exercising pointer wrap.
- Reset mid-operation: after 5 puts, assert reset together with get_req -> next cycle data_valid=0, count=0, empty=1, both pointers 0. A subsequent put 0x7 then get returns 0x7.
